jug_elecul_sch: RTL and testbench
=================================

JUG_ELECUL_SCH -- requirements
Module: jug_elecul_sch

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 8, giving the number of scanned channels (2..16).
REQ-002 The block SHALL have parameter DEB_NUM, default 3, giving the consecutive disagreeing samples needed to toggle a fault flag (1..15).
REQ-003 The block SHALL have parameter TMO_NUM, default 15, giving the sample-wait timeout in cycles (1..255).
REQ-004 The block SHALL have port clk_sys, input, 1, as the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_sys, input, 1, as the synchronous active-high reset.
REQ-006 The block SHALL have port scan_start, input, 1, a pulse requesting one full scan of all channels.
REQ-007 The block SHALL have port cfg_wr, input, 1, a limit-table write strobe.
REQ-008 The block SHALL have port cfg_addr, input, 4, the limit-table channel index.
REQ-009 The block SHALL have port cfg_data, input, 16, the unsigned upper-limit value.
REQ-010 The block SHALL have port smp_req, output, 1, a level request for a sample.
REQ-011 The block SHALL have port smp_ch, output, 4, the requested channel index.
REQ-012 The block SHALL have port smp_vld, input, 1, a single-cycle sample-valid pulse.
REQ-013 The block SHALL have port smp_data, input, 16, an unsigned sample, valid with smp_vld.
REQ-014 The block SHALL have port fault_flag, output, CH_NUM, the per-channel debounced over-limit flags.
REQ-015 The block SHALL have port tmo_flag, output, CH_NUM, the sticky per-channel sample-timeout flags.
REQ-016 The block SHALL have ports busy, output, 1, high while a scan runs, and scan_done, output, 1, a one-cycle pulse at scan end.
REQ-017 The block SHALL have port cfg_err, output, 1, a one-cycle pulse on a rejected cfg_wr.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, CMP, UPD and DONE.
REQ-019 In IDLE, scan_start SHALL set ch=0 and move to REQ on the next cycle, with busy high from that cycle.
REQ-020 scan_start outside IDLE SHALL be ignored.
REQ-021 In REQ, smp_req SHALL be 1 and smp_ch SHALL equal ch.
REQ-022 In REQ, the first smp_vld SHALL latch smp_data, drop smp_req and move to CMP.
REQ-023 smp_vld outside REQ SHALL be ignored.
REQ-024 If smp_vld is absent for TMO_NUM cycles in REQ, the block SHALL set tmo_flag[ch], leave fault_flag[ch] and its counter unchanged, and move to UPD-skip (next channel).
REQ-025 A sample that arrives later SHALL clear tmo_flag[ch].
REQ-026 CMP SHALL register over = (sample > limit[ch]) as a strict unsigned 16-bit compare, so equality is not over.
REQ-027 In UPD, if over differs from fault_flag[ch], deb_cnt[ch] SHALL increment.
REQ-028 In UPD, when deb_cnt[ch] reaches DEB_NUM, fault_flag[ch] SHALL toggle and deb_cnt[ch] SHALL clear.
REQ-029 In UPD, if over equals fault_flag[ch], deb_cnt[ch] SHALL clear.
REQ-030 After UPD, the block SHALL go to REQ with ch+1, or to DONE when ch = CH_NUM-1.
REQ-031 DONE SHALL last one cycle, pulse scan_done, and return to IDLE with busy low in that same cycle.
REQ-032 Latency from scan_start to scan_done SHALL be 1 + sum over channels of (REQ cycles + 2) + 1 cycles; with zero-wait smp_vld and CH_NUM=8 this is 26 cycles.
REQ-033 A cfg_wr in IDLE with cfg_addr < CH_NUM SHALL write limit[cfg_addr] at the next edge.
REQ-034 A cfg_wr while busy, or with cfg_addr >= CH_NUM, SHALL leave the table unchanged and pulse cfg_err on the next cycle.

Reset
REQ-035 rst_sys SHALL, at any state including mid-scan, synchronously force IDLE, ch=0, smp_req=0, busy=0, scan_done=0, cfg_err=0, all fault_flag, tmo_flag and deb_cnt to 0, and all limit entries to 16'hFFFF (never over).
REQ-036 rst_sys SHALL dominate scan_start, cfg_wr and smp_vld in the same cycle.

Configuration
REQ-037 When macro ELECUL_HYST_EN is defined, the block SHALL add input hyst, 16, and, while fault_flag[ch]=1, compute over = (sample + hyst > limit[ch]) with a 17-bit sum, so clearing requires sample <= limit - hyst.
REQ-038 When ELECUL_HYST_EN is undefined, the hyst port SHALL be absent and REQ-026 SHALL apply unconditionally.

Verification
REQ-039 Reset, write limit[2]=1000, scan 3x with ch2 sample 1001 -> fault_flag[2]=1 after the 3rd scan_done, not before.
REQ-040 With fault set, scan with ch2 sample 1000 twice, then 1001, then 1000 three times -> flag stays 1 until the 3rd consecutive 1000, then clears.
REQ-041 Withhold smp_vld for ch5 -> smp_req drops after 15 cycles, tmo_flag[5]=1, scan completes, and fault_flag[5] is unchanged.
REQ-042 Issue cfg_wr during a scan and with cfg_addr=9 (CH_NUM=8) -> cfg_err pulses and the table is unchanged; scan_start while busy is ignored.
REQ-043 Assert rst_sys while in REQ for ch4 -> next cycle busy=0, smp_req=0, flags are 0, and a new scan_start restarts at ch0.
REQ-044 With ELECUL_HYST_EN defined, hyst=50, limit=1000 and fault set, samples of 960 x3 -> flag stays 1; samples of 950 x3 -> flag clears.

Source files
------------

// File: rtl/jug_elecul_sch.sv
// jug_elecul_sch: sequential limit scanner with per-channel debounced over-limit
// flags and sticky sample-timeout flags.
// Optional feature: define ELECUL_HYST_EN to add the hyst input, which applies
// release hysteresis to channels whose fault flag is currently set.
module jug_elecul_sch #(
  parameter int CH_NUM  = 8,   // scanned channels, 2..16
  parameter int DEB_NUM = 3,   // consecutive disagreeing samples to toggle a flag, 1..15
  parameter int TMO_NUM = 15   // sample-wait timeout in cycles, 1..255
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              scan_start,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_data,
`ifdef ELECUL_HYST_EN
  input  logic [15:0]       hyst,
`endif
  output logic              smp_req,
  output logic [3:0]        smp_ch,
  input  logic              smp_vld,
  input  logic [15:0]       smp_data,
  output logic [CH_NUM-1:0] fault_flag,
  output logic [CH_NUM-1:0] tmo_flag,
  output logic              busy,
  output logic              scan_done,
  output logic              cfg_err
);

  localparam int         CW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [3:0] LAST_CH  = 4'(CH_NUM - 1);
  localparam logic [7:0] TMO_LAST = 8'(TMO_NUM - 1);
  localparam logic [3:0] DEB_LIM  = 4'(DEB_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CMP,
    S_UPD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        ch_q, ch_d;          // channel being scanned
  logic [7:0]        wait_q, wait_d;      // cycles spent waiting in REQ
  logic [15:0]       sample_q, sample_d;  // latched sample of current channel
  logic              over_q, over_d;      // registered compare result
  logic              skip_q, skip_d;      // channel timed out: UPD leaves it alone
  logic              cfg_err_q, cfg_err_d;
  logic [CH_NUM-1:0] fault_q, fault_d;
  logic [CH_NUM-1:0] tmo_q, tmo_d;
  logic [3:0]        deb_q   [CH_NUM];
  logic [3:0]        deb_d   [CH_NUM];
  logic [15:0]       limit_q [CH_NUM];
  logic [15:0]       limit_d [CH_NUM];

  logic [CW-1:0]     ch_idx;
  logic [CW-1:0]     cfg_idx;
  logic              cfg_ok;
  logic [3:0]        deb_inc;
  logic [16:0]       cmp_lhs;

  assign ch_idx     = ch_q[CW-1:0];
  assign cfg_idx    = cfg_addr[CW-1:0];
  assign cfg_ok     = ({1'b0, cfg_addr} < 5'(CH_NUM));
  assign smp_ch     = ch_q;
  assign fault_flag = fault_q;
  assign tmo_flag   = tmo_q;
  assign cfg_err    = cfg_err_q;

  // FSM next-state and state-decoded outputs
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    smp_req   = 1'b0;
    busy      = 1'b0;
    scan_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_start) state_d = S_REQ;
      end
      S_REQ: begin
        smp_req = 1'b1;
        busy    = 1'b1;
        if (smp_vld)                 state_d = S_CMP;
        else if (wait_q == TMO_LAST) state_d = S_UPD;
      end
      S_CMP: begin
        busy    = 1'b1;
        state_d = S_UPD;
      end
      S_UPD: begin
        busy    = 1'b1;
        state_d = (ch_q == LAST_CH) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        scan_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: limit table writes, sample capture, compare, debounce
  always_comb begin
    ch_d      = ch_q;
    wait_d    = wait_q;
    sample_d  = sample_q;
    over_d    = over_q;
    skip_d    = skip_q;
    fault_d   = fault_q;
    tmo_d     = tmo_q;
    deb_d     = deb_q;
    limit_d   = limit_q;
    cfg_err_d = 1'b0;
    deb_inc   = deb_q[ch_idx] + 4'd1;
    cmp_lhs   = {1'b0, sample_q};
`ifdef ELECUL_HYST_EN
    // A set flag only releases once the sample is at least hyst below the limit.
    if (fault_q[ch_idx]) cmp_lhs = {1'b0, sample_q} + {1'b0, hyst};
`endif

    // The table is only writable while idle; anything else is rejected.
    if (cfg_wr) begin
      if (state_q == S_IDLE && cfg_ok) limit_d[cfg_idx] = cfg_data;
      else                             cfg_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          ch_d   = '0;
          wait_d = '0;
        end
      end
      S_REQ: begin
        if (smp_vld) begin
          sample_d      = smp_data;
          skip_d        = 1'b0;
          tmo_d[ch_idx] = 1'b0;
        end else if (wait_q == TMO_LAST) begin
          skip_d        = 1'b1;
          tmo_d[ch_idx] = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_CMP: begin
        over_d = (cmp_lhs > {1'b0, limit_q[ch_idx]});
      end
      S_UPD: begin
        if (!skip_q) begin
          if (over_q != fault_q[ch_idx]) begin
            if (deb_inc == DEB_LIM) begin
              fault_d[ch_idx] = ~fault_q[ch_idx];
              deb_d[ch_idx]   = '0;
            end else begin
              deb_d[ch_idx] = deb_inc;
            end
          end else begin
            deb_d[ch_idx] = '0;
          end
        end
        if (ch_q != LAST_CH) begin
          ch_d   = ch_q + 4'd1;
          wait_d = '0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_sys) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      wait_q    <= '0;
      sample_q  <= '0;
      over_q    <= 1'b0;
      skip_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      fault_q   <= '0;
      tmo_q     <= '0;
      // NOTE: the limit table is built from flops and is reset on purpose: its
      // all-ones value means "never over", so a fresh scan cannot raise faults.
      for (int i = 0; i < CH_NUM; i++) begin
        deb_q[i]   <= '0;
        limit_q[i] <= 16'hFFFF;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      wait_q    <= wait_d;
      sample_q  <= sample_d;
      over_q    <= over_d;
      skip_q    <= skip_d;
      cfg_err_q <= cfg_err_d;
      fault_q   <= fault_d;
      tmo_q     <= tmo_d;
      deb_q     <= deb_d;
      limit_q   <= limit_d;
    end
  end

endmodule

// File: tb/tb_jug_elecul_sch.sv
// tb_jug_elecul_sch: directed scoreboard bench for jug_elecul_sch.
// The driver pushes expected scan results and cfg_err timing into queues; an
// independent monitor pops and compares them when scan_done / cfg_err appear.
module tb_jug_elecul_sch;

  localparam int CH = 8;

  logic          clk_sys = 1'b0;
  logic          rst_sys;
  logic          scan_start;
  logic          cfg_wr;
  logic [3:0]    cfg_addr;
  logic [15:0]   cfg_data;
  logic          smp_req;
  logic [3:0]    smp_ch;
  logic          smp_vld;
  logic [15:0]   smp_data;
  logic [CH-1:0] fault_flag;
  logic [CH-1:0] tmo_flag;
  logic          busy;
  logic          scan_done;
  logic          cfg_err;
`ifdef ELECUL_HYST_EN
  logic [15:0]   hyst;
`endif

  typedef struct {
    logic [CH-1:0] fault;
    logic [CH-1:0] tmo;
    int            lat;    // 0: latency not checked
    int            start;  // cycle in which scan_start was presented
  } scan_exp_t;

  scan_exp_t   scan_q[$];
  int          cfg_q[$];   // cycle in which cfg_err is expected
  int          n_vec      = 0;
  int          n_err      = 0;
  int          cyc        = 0;
  int          scans_done = 0;
  logic [15:0] smp_val [CH];
  int          smp_dly [CH];  // cycles of smp_req before answering; >=255 never

  jug_elecul_sch #(.CH_NUM(CH), .DEB_NUM(3), .TMO_NUM(15)) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .scan_start (scan_start),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
`ifdef ELECUL_HYST_EN
    .hyst       (hyst),
`endif
    .smp_req    (smp_req),
    .smp_ch     (smp_ch),
    .smp_vld    (smp_vld),
    .smp_data   (smp_data),
    .fault_flag (fault_flag),
    .tmo_flag   (tmo_flag),
    .busy       (busy),
    .scan_done  (scan_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  // Sample source: answers smp_req after smp_dly cycles with a one-cycle pulse.
  initial begin : responder
    int wcnt;
    wcnt     = 0;
    smp_vld  = 1'b0;
    smp_data = '0;
    forever begin
      @(negedge clk_sys);
      smp_vld = 1'b0;
      if (smp_req === 1'b1 && int'(smp_ch) < CH) begin
        if (wcnt == smp_dly[int'(smp_ch)]) begin
          smp_vld  = 1'b1;
          smp_data = smp_val[int'(smp_ch)];
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: compares DUT responses against the scoreboard queues.
  initial begin : monitor
    scan_exp_t e;
    int        ec;
    forever begin
      @(negedge clk_sys);
      if (scan_done === 1'b1) begin
        if (scan_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_scan_done @cyc %0d: got scan_done 1, expected 0", cyc);
        end else begin
          e = scan_q.pop_front();
          check("scan_fault", 32'(fault_flag), 32'(e.fault));
          check("scan_tmo", 32'(tmo_flag), 32'(e.tmo));
          if (e.lat != 0) check("scan_latency", 32'(cyc - e.start + 1), 32'(e.lat));
          scans_done++;
        end
      end
      if (cfg_err === 1'b1) begin
        if (cfg_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_cfg_err @cyc %0d: got cfg_err 1, expected 0", cyc);
        end else begin
          ec = cfg_q.pop_front();
          check("cfg_err_cycle", 32'(cyc), 32'(ec));
        end
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d, input bit exp_err);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    if (exp_err) cfg_q.push_back(cyc + 1);
    tick();
    cfg_wr = 1'b0;
  endtask

  // One scan; disturb adds a rejected cfg_wr and an ignored scan_start mid-scan,
  // meas_ch >= 0 measures how long smp_req stays up for that channel.
  task automatic run_scan(input logic [CH-1:0] ef, input logic [CH-1:0] et, input int lat,
                          input bit disturb, input int meas_ch);
    scan_exp_t e;
    int        target;
    int        cnt;
    e.fault = ef;
    e.tmo   = et;
    e.lat   = lat;
    e.start = cyc;
    target  = scans_done + 1;
    scan_q.push_back(e);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("busy_at_start", 32'(busy), 32'd1);
    check("first_req_ch0", 32'({smp_req, smp_ch}), 32'h10);
    if (disturb) begin
      tick(4);
      cfg_write(4'd3, 16'd0, 1'b1);
      tick(2);
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
    end
    if (meas_ch >= 0) begin
      for (int i = 0; i < 200 && !(smp_req === 1'b1 && int'(smp_ch) == meas_ch); i++) tick();
      cnt = 0;
      while (smp_req === 1'b1 && cnt < 100) begin
        cnt++;
        tick();
      end
      check("req_len_timeout", 32'(cnt), 32'd15);
    end
    for (int i = 0; i < 400 && scans_done < target; i++) tick();
    if (scans_done < target) begin
      n_vec++;
      n_err++;
      $display("FAIL scan_timeout @cyc %0d: got no scan_done, expected one", cyc);
      scan_q.delete();
    end
    tick();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst_sys    = 1'b1;
    scan_start = 1'b1;
    cfg_wr     = 1'b1;
    cfg_addr   = 4'd0;
    cfg_data   = 16'd0;
`ifdef ELECUL_HYST_EN
    hyst       = 16'd0;
`endif
    for (int i = 0; i < CH; i++) begin
      smp_val[i] = 16'd100;
      smp_dly[i] = 0;
    end

    // Reset dominates scan_start and cfg_wr
    tick(3);
    rst_sys    = 1'b0;
    scan_start = 1'b0;
    cfg_wr     = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_smp_req", 32'(smp_req), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_fault", 32'(fault_flag), 32'd0);
    check("rst_tmo", 32'(tmo_flag), 32'd0);
    tick();
    check("rst_no_scan", 32'(busy), 32'd0);

    // Over-limit on ch2 and ch5 sets the flags on the third scan only
    cfg_write(4'd2, 16'd1000, 1'b0);
    cfg_write(4'd5, 16'd1000, 1'b0);
    smp_val[2] = 16'd1001;
    smp_val[5] = 16'd1001;
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);

    // Equality is not over; an agreeing sample restarts the debounce
    smp_val[2] = 16'd1000;
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);
    smp_val[2] = 16'd1001;
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);
    smp_val[2] = 16'd1000;
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);
    run_scan(8'h24, 8'h00, 26, 1'b0, -1);
    run_scan(8'h20, 8'h00, 26, 1'b0, -1);

    // ch5 times out: tmo set, fault and debounce untouched across three scans
    smp_val[5] = 16'd0;
    smp_dly[5] = 255;
    run_scan(8'h20, 8'h20, 0, 1'b0, 5);
    run_scan(8'h20, 8'h20, 0, 1'b0, -1);
    run_scan(8'h20, 8'h20, 0, 1'b0, -1);

    // A later sample clears the timeout flag
    smp_dly[5] = 0;
    smp_val[5] = 16'd1001;
    run_scan(8'h20, 8'h00, 26, 1'b0, -1);

    // Rejected writes (bad address, while busy) and ignored scan_start
    smp_val[1] = 16'd500;
    smp_val[3] = 16'd500;
    cfg_write(4'd9, 16'd0, 1'b1);
    tick();
    run_scan(8'h20, 8'h00, 26, 1'b1, -1);
    run_scan(8'h20, 8'h00, 26, 1'b0, -1);
    run_scan(8'h20, 8'h00, 26, 1'b0, -1);

    // Reset while requesting ch4, then a fresh scan restarts at ch0
    smp_dly[4] = 255;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 200 && !(smp_req === 1'b1 && smp_ch == 4'd4); i++) tick();
    check("reach_ch4", 32'({smp_req, smp_ch}), 32'h14);
    tick(2);
    rst_sys = 1'b1;
    tick();
    rst_sys = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_smp_req", 32'(smp_req), 32'd0);
    check("midrst_fault", 32'(fault_flag), 32'd0);
    check("midrst_tmo", 32'(tmo_flag), 32'd0);
    check("midrst_scan_done", 32'(scan_done), 32'd0);
    smp_dly[4] = 0;
    tick();
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);

`ifdef ELECUL_HYST_EN
    // Hysteresis: release needs sample <= limit - hyst
    cfg_write(4'd2, 16'd1000, 1'b0);
    hyst       = 16'd50;
    smp_val[2] = 16'd1001;
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    smp_val[2] = 16'd960;
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    smp_val[2] = 16'd950;
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    run_scan(8'h04, 8'h00, 26, 1'b0, -1);
    run_scan(8'h00, 8'h00, 26, 1'b0, -1);
`endif

    tick(3);
    check("scan_q_drained", 32'(scan_q.size()), 32'd0);
    check("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
